// File: rtl/regfile_writeback.sv
// Write-port driver for the 32x32 register file: MEM/WB register, 2-entry late-result buffer
// for the multi-cycle unit, and write-port arbitration. Optional bypass under WB_BYPASS_EN.

module regfile_writeback #(
  parameter int unsigned LATE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        Rest,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic        mem_mem_to_reg,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic        late_valid,
  input  logic [4:0]  late_dest,
  input  logic [31:0] late_data,
  output logic        late_ready,
  output logic        write_sig,
  output logic [4:0]  d_addr,
  output logic [31:0] writeback_data,
  output logic        late_busy,
  input  logic [4:0]  a_addr,
  input  logic [4:0]  b_addr,
  output logic        a_fwd,
  output logic        b_fwd,
  output logic [31:0] a_fwd_data,
  output logic [31:0] b_fwd_data
);

  // MEM/WB pipeline register
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;

  // Late-result FIFO
  logic [1:0][4:0]  buf_dest_q, buf_dest_d;
  logic [1:0][31:0] buf_data_q, buf_data_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;

  logic        head_valid;
  logic [4:0]  head_dest;
  logic [31:0] head_data;
  logic        push_store;
  logic        pop;

  always_comb begin
    wb_we_d   = mem_valid & mem_reg_write & (mem_dest != 5'd0);
    wb_dest_d = mem_dest;
    wb_data_d = mem_mem_to_reg ? mem_load_data : mem_alu_result;
  end

  // Ready depends only on the count flop, so late_valid never loops back into it.
  assign late_ready = (count_q != 2'(LATE_DEPTH));
  assign late_busy  = (count_q != 2'd0);

  assign head_valid = (count_q != 2'd0);
  assign head_dest  = buf_dest_q[rd_ptr_q];
  assign head_data  = buf_data_q[rd_ptr_q];

  // Results for r0 are accepted so the multi-cycle unit can retire them, but never stored.
  assign push_store = late_valid & late_ready & (late_dest != 5'd0);

  always_comb begin
    write_sig      = 1'b0;
    d_addr         = 5'd0;
    writeback_data = 32'd0;
    pop            = 1'b0;
    if (wb_we_q) begin
      write_sig      = 1'b1;
      d_addr         = wb_dest_q;
      writeback_data = wb_data_q;
      // The pipeline value is newer in program order, so a matching head is stale.
      pop            = head_valid & (head_dest == wb_dest_q);
    end else if (head_valid) begin
      write_sig      = 1'b1;
      d_addr         = head_dest;
      writeback_data = head_data;
      pop            = 1'b1;
    end
  end

  always_comb begin
    buf_dest_d = buf_dest_q;
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_store) begin
      buf_dest_d[wr_ptr_q] = late_dest;
      buf_data_d[wr_ptr_q] = late_data;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_store, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge Rest) begin
    if (Rest) begin
      wb_we_q    <= 1'b0;
      wb_dest_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      buf_dest_q <= '0;
      buf_data_q <= '0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      wb_we_q    <= wb_we_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      buf_dest_q <= buf_dest_d;
      buf_data_q <= buf_data_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    a_fwd      = write_sig & (a_addr == d_addr);
    b_fwd      = write_sig & (b_addr == d_addr);
    a_fwd_data = a_fwd ? writeback_data : 32'd0;
    b_fwd_data = b_fwd ? writeback_data : 32'd0;
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{a_addr, b_addr};

  always_comb begin
    a_fwd      = 1'b0;
    b_fwd      = 1'b0;
    a_fwd_data = 32'd0;
    b_fwd_data = 32'd0;
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; expectations are hand-computed per step.

module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        Rest;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_load_data;
  logic        late_valid;
  logic [4:0]  late_dest;
  logic [31:0] late_data;
  logic        late_ready, write_sig, late_busy;
  logic [4:0]  d_addr;
  logic [31:0] writeback_data;
  logic [4:0]  a_addr, b_addr;
  logic        a_fwd, b_fwd;
  logic [31:0] a_fwd_data, b_fwd_data;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.LATE_DEPTH(2)) dut (
    .clock          (clock),
    .Rest           (Rest),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .late_valid     (late_valid),
    .late_dest      (late_dest),
    .late_data      (late_data),
    .late_ready     (late_ready),
    .write_sig      (write_sig),
    .d_addr         (d_addr),
    .writeback_data (writeback_data),
    .late_busy      (late_busy),
    .a_addr         (a_addr),
    .b_addr         (b_addr),
    .a_fwd          (a_fwd),
    .b_fwd          (b_fwd),
    .a_fwd_data     (a_fwd_data),
    .b_fwd_data     (b_fwd_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the whole write port in one call.
  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, ".we"}, 32'(write_sig), 32'(we));
    chk({tag, ".addr"}, 32'(d_addr), 32'(addr));
    chk({tag, ".data"}, writeback_data, data);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_wr(tag, 1'b0, 5'd0, 32'd0);
    chk({tag, ".ready"}, 32'(late_ready), 32'd1);
    chk({tag, ".busy"}, 32'(late_busy), 32'd0);
    chk({tag, ".afwd"}, 32'(a_fwd), 32'd0);
    chk({tag, ".bfwd"}, 32'(b_fwd), 32'd0);
    chk({tag, ".afd"}, a_fwd_data, 32'd0);
    chk({tag, ".bfd"}, b_fwd_data, 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] dst, input logic [31:0] alu,
                      input logic [31:0] ld, input logic m2r);
    mem_valid      = v;
    mem_reg_write  = v;
    mem_dest       = dst;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_mem_to_reg = m2r;
  endtask

  task automatic late(input logic v, input logic [4:0] dst, input logic [31:0] dat);
    late_valid = v;
    late_dest  = dst;
    late_data  = dat;
  endtask

  initial begin
    Rest   = 1'b1;
    a_addr = 5'd0;
    b_addr = 5'd0;
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    late(1'b0, 5'd0, 32'd0);
    #3;
    chk_reset_vals("por");
    #4 Rest = 1'b0;
    step();

    // ALU then load selection
    pipe(1'b1, 5'd5, 32'h11, 32'h22, 1'b0);
    step();
    chk_wr("alu", 1'b1, 5'd5, 32'h11);
    mem_mem_to_reg = 1'b1;
    step();
    chk_wr("load", 1'b1, 5'd5, 32'h22);
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk_wr("idle", 1'b0, 5'd0, 32'd0);

    // r0 suppression on both paths
    pipe(1'b1, 5'd0, 32'h77, 32'd0, 1'b0);
    step();
    chk_wr("r0pipe", 1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    late(1'b1, 5'd0, 32'h55);
    step();
    late(1'b0, 5'd0, 32'd0);
    chk("r0late.busy", 32'(late_busy), 32'd0);
    chk("r0late.ready", 32'(late_ready), 32'd1);
    step();
    chk_wr("r0late", 1'b0, 5'd0, 32'd0);

    // Priority and draining
    pipe(1'b1, 5'd9, 32'h90, 32'd0, 1'b0);
    late(1'b1, 5'd7, 32'hAA);
    step();
    chk_wr("pri1", 1'b1, 5'd9, 32'h90);
    chk("pri1.ready", 32'(late_ready), 32'd1);
    chk("pri1.busy", 32'(late_busy), 32'd1);
    late(1'b1, 5'd8, 32'hBB);
    step();
    chk_wr("pri2", 1'b1, 5'd9, 32'h90);
    chk("pri2.ready", 32'(late_ready), 32'd0);
    late(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("pri3", 1'b1, 5'd9, 32'h90);
    chk("pri3.ready", 32'(late_ready), 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk_wr("drain7", 1'b1, 5'd7, 32'hAA);
    step();
    chk_wr("drain8", 1'b1, 5'd8, 32'hBB);
    chk("drain8.ready", 32'(late_ready), 32'd1);
    step();
    chk_wr("drained", 1'b0, 5'd0, 32'd0);
    chk("drained.busy", 32'(late_busy), 32'd0);

    // Same-destination discard
    pipe(1'b1, 5'd4, 32'h2, 32'd0, 1'b0);
    late(1'b1, 5'd4, 32'h1);
    step();
    chk_wr("same", 1'b1, 5'd4, 32'h2);
    chk("same.busy", 32'(late_busy), 32'd1);
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    late(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("same.after", 1'b0, 5'd0, 32'd0);
    chk("same.busy2", 32'(late_busy), 32'd0);

    // Simultaneous push and pop with pointer wrap
    late(1'b1, 5'd13, 32'h33);
    step();
    chk_wr("pp1", 1'b1, 5'd13, 32'h33);
    late(1'b1, 5'd14, 32'h44);
    step();
    chk_wr("pp2", 1'b1, 5'd14, 32'h44);
    chk("pp2.ready", 32'(late_ready), 32'd1);
    chk("pp2.busy", 32'(late_busy), 32'd1);
    late(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("pp3", 1'b0, 5'd0, 32'd0);
    chk("pp3.busy", 32'(late_busy), 32'd0);

    // Bypass
    pipe(1'b1, 5'd3, 32'hCAFE, 32'd0, 1'b0);
    a_addr = 5'd3;
    b_addr = 5'd4;
    step();
    chk_wr("byp", 1'b1, 5'd3, 32'hCAFE);
`ifdef WB_BYPASS_EN
    chk("byp.afwd", 32'(a_fwd), 32'd1);
    chk("byp.afd", a_fwd_data, 32'hCAFE);
`else
    chk("byp.afwd", 32'(a_fwd), 32'd0);
    chk("byp.afd", a_fwd_data, 32'd0);
`endif
    chk("byp.bfwd", 32'(b_fwd), 32'd0);
    chk("byp.bfd", b_fwd_data, 32'd0);
    a_addr = 5'd0;
    b_addr = 5'd0;

    // Reset mid-cycle with two entries buffered
    pipe(1'b1, 5'd10, 32'h10, 32'd0, 1'b0);
    late(1'b1, 5'd11, 32'h111);
    step();
    late(1'b1, 5'd12, 32'h222);
    step();
    chk("pre_rst.ready", 32'(late_ready), 32'd0);
    late(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #2 Rest = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clock);
    #2 Rest = 1'b0;
    step();
    chk_wr("postrst1", 1'b0, 5'd0, 32'd0);
    chk("postrst1.busy", 32'(late_busy), 32'd0);
    step();
    chk_wr("postrst2", 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
